imem_loader: RTL and testbench

//   Write-side counterpart of the instruction memory: receives a framed byte stream
//   (e.g. from a UART RX) and writes 32-bit words into IMEM through its write port.

---
 rtl/imem_loader_if.sv | 38 +++
 rtl/imem_loader.sv | 172 +++++++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the byte-stream handshake and the IMEM write / status signals of
//   the instruction-memory loader.
//   Signals:
//     rxValid, rxData   byte stream into the loader
//     rxReady           loader can accept a byte this cycle
//     imemWEn           single-cycle IMEM write strobe
//     imemAddr          IMEM word address for the write
//     imemWData         IMEM write data
//     cpuHold           keep the processor PC in reset
//     loadDone          last load completed OK (sticky)
//     loadErr           last load failed (sticky)
//   Modports:
//     master  the loader (drives rxReady, the write port and the status)
//     slave   the environment (drives rxValid/rxData, observes the rest)
interface imem_loader_if #(
  parameter int ADDR_W = 4
);
  logic              rxValid;
  logic [7:0]        rxData;
  logic              rxReady;
  logic              imemWEn;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemWData;
  logic              cpuHold;
  logic              loadDone;
  logic              loadErr;

  modport master (
    input  rxValid, rxData,
    output rxReady, imemWEn, imemAddr, imemWData, cpuHold, loadDone, loadErr
  );

  modport slave (
    output rxValid, rxData,
    input  rxReady, imemWEn, imemAddr, imemWData, cpuHold, loadDone, loadErr
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Receives a framed byte stream (0xA5 sync, word count N, N*4 little-endian
//   data bytes, optional checksum byte) and writes 32-bit words into IMEM.
//   Holds the processor off while an image loads, releases it on success and
//   flags count/timeout/checksum errors.
//   Ports:
//     sysCLK  system clock, all state on posedge
//     nRST    asynchronous active-low reset
//     bus     imem_loader_if.master (byte handshake, IMEM write port, status)
//   Parameters:
//     ADDR_W   IMEM word-address width (<= 8); image limited to 2**ADDR_W words
//     TIMEOUT  idle cycles allowed between accepted bytes mid-frame; 0 disables
//   Build option:
//     LOADER_CHECKSUM_EN  when defined, a trailing byte equal to the XOR of all
//                         data bytes is required before the load is declared done.
module imem_loader #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1024
) (
  input logic         sysCLK,
  input logic         nRST,
  imem_loader_if.master bus
);

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam logic [8:0] MAX_N = 9'(1 << ADDR_W);
  localparam int         TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   words_left;
  logic [1:0]        byte_cnt;
  logic [TW-1:0]     timer;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr;
  logic              hold, done, err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic       accept;
  logic       is_sync;
  logic       start;
  logic       timed;
  logic       timeout_hit;
  logic [8:0] n_ext;
  logic       n_bad;

  assign bus.rxReady   = (state != WRITE);
  assign bus.imemWEn   = (state == WRITE);
  assign bus.imemAddr  = addr;
  assign bus.imemWData = word;
  assign bus.cpuHold   = hold;
  assign bus.loadDone  = done;
  assign bus.loadErr   = err;

  assign accept  = bus.rxValid && bus.rxReady;
  assign is_sync = (bus.rxData == SYNC);
  assign start   = accept && is_sync &&
                   (state == IDLE || state == DONE || state == ERR);
  assign n_ext   = {1'b0, bus.rxData};
  assign n_bad   = (n_ext == 9'd0) || (n_ext > MAX_N);

`ifdef LOADER_CHECKSUM_EN
  assign timed = (state == COUNT) || (state == DATA) || (state == CHECK);
`else
  assign timed = (state == COUNT) || (state == DATA);
`endif
  // An accepted byte on the expiring cycle still counts as on time.
  assign timeout_hit = (TIMEOUT != 0) && timed && !accept && (timer == T_LAST);

  always_ff @(posedge sysCLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = COUNT;
      COUNT: begin
        if (accept)           state_nxt = n_bad ? ERR : DATA;
        else if (timeout_hit) state_nxt = ERR;
      end
      DATA: begin
        if (accept && byte_cnt == 2'd3) state_nxt = WRITE;
        else if (timeout_hit)           state_nxt = ERR;
      end
      WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        if (words_left == 1) state_nxt = CHECK;
`else
        if (words_left == 1) state_nxt = DONE;
`endif
        else                 state_nxt = DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept)           state_nxt = (bus.rxData == csum) ? DONE : ERR;
        else if (timeout_hit) state_nxt = ERR;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysCLK or negedge nRST) begin
    if (!nRST) begin
      words_left <= '0;
      byte_cnt   <= '0;
      timer      <= '0;
      word       <= '0;
      addr       <= '0;
      hold       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      if (timed && !accept) timer <= timer + 1'b1;
      else                  timer <= '0;

      if (start) begin
        hold     <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
        addr     <= '0;
        byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end

      if (state == COUNT && accept && !n_bad) words_left <= n_ext[ADDR_W:0];

      // Little-endian assembly: the first byte ends up in [7:0].
      if (state == DATA && accept) begin
        word     <= {bus.rxData, word[31:8]};
        byte_cnt <= byte_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        csum     <= csum ^ bus.rxData;
`endif
      end

      // The address stays on the last written word so a full image cannot wrap it.
      if (state == WRITE) begin
        words_left <= words_left - 1'b1;
        if (words_left != 1) addr <= addr + 1'b1;
      end

      if (state_nxt == DONE && state != DONE) begin
        hold <= 1'b0;
        done <= 1'b1;
      end
      if (state_nxt == ERR && state != ERR) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_pass;

  logic [3:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader_if #(.ADDR_W(4)) bus ();

  imem_loader #(.ADDR_W(4), .TIMEOUT(16)) dut (
    .sysCLK(clk),
    .nRST  (nrst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every IMEM write seen in the middle of its cycle.
  always @(negedge clk) begin
    if (bus.imemWEn === 1'b1) begin
      wr_addr.push_back(bus.imemAddr);
      wr_data.push_back(bus.imemWData);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  // Called on a negedge; returns on the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rxValid = 1'b1;
    bus.rxData  = b;
    while (bus.rxReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_checks++;
      $display("FAIL send_byte_wait rxReady=%b required=1", bus.rxReady);
    end
    @(posedge clk);
    @(negedge clk);
    bus.rxValid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxData  = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.rxReady !== 1'b1) $display("FAIL rst_rxReady got=%b want=1", bus.rxReady); else n_pass++;
    n_checks++; if (bus.imemWEn !== 1'b0) $display("FAIL rst_imemWEn got=%b want=0", bus.imemWEn); else n_pass++;
    n_checks++; if (bus.imemAddr !== 4'd0) $display("FAIL rst_imemAddr got=%h want=0", bus.imemAddr); else n_pass++;
    n_checks++; if (bus.imemWData !== 32'd0) $display("FAIL rst_imemWData got=%h want=0", bus.imemWData); else n_pass++;
    n_checks++; if (bus.cpuHold !== 1'b0) $display("FAIL rst_cpuHold got=%b want=0", bus.cpuHold); else n_pass++;
    n_checks++; if (bus.loadDone !== 1'b0) $display("FAIL rst_loadDone got=%b want=0", bus.loadDone); else n_pass++;
    n_checks++; if (bus.loadErr !== 1'b0) $display("FAIL rst_loadErr got=%b want=0", bus.loadErr); else n_pass++;
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_drop();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'h02);
    repeat (2) @(negedge clk);
    n_checks++; if (bus.cpuHold !== 1'b0) $display("FAIL drop_cpuHold got=%b want=0", bus.cpuHold); else n_pass++;
    n_checks++; if (bus.loadDone !== 1'b0 || bus.loadErr !== 1'b0)
      $display("FAIL drop_status got=%b%b want=00", bus.loadDone, bus.loadErr); else n_pass++;
    n_checks++; if (wr_addr.size() != 0) $display("FAIL drop_writes got=%0d want=0", wr_addr.size()); else n_pass++;
  endtask

  task automatic test_load(input string tag);
    clear_log();
    send_byte(8'hA5);
    n_checks++; if (bus.cpuHold !== 1'b1) $display("FAIL %s_hold_start got=%b want=1", tag, bus.cpuHold); else n_pass++;
    send_byte(8'h02);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    n_checks++; if (bus.imemWEn !== 1'b1 || bus.imemAddr !== 4'd0 || bus.imemWData !== 32'h12345678)
      $display("FAIL %s_write_latency got=%b/%h/%h want=1/0/12345678", tag, bus.imemWEn, bus.imemAddr, bus.imemWData);
    else n_pass++;
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h2A);
`endif
    repeat (2) @(negedge clk);
    n_checks++; if (wr_addr.size() != 2) $display("FAIL %s_nwrites got=%0d want=2", tag, wr_addr.size()); else n_pass++;
    if (wr_addr.size() == 2) begin
      n_checks++; if (wr_addr[0] !== 4'd0 || wr_data[0] !== 32'h12345678)
        $display("FAIL %s_word0 got=%h:%h want=0:12345678", tag, wr_addr[0], wr_data[0]); else n_pass++;
      n_checks++; if (wr_addr[1] !== 4'd1 || wr_data[1] !== 32'hDEADBEEF)
        $display("FAIL %s_word1 got=%h:%h want=1:deadbeef", tag, wr_addr[1], wr_data[1]); else n_pass++;
    end
    n_checks++; if (bus.loadDone !== 1'b1) $display("FAIL %s_loadDone got=%b want=1", tag, bus.loadDone); else n_pass++;
    n_checks++; if (bus.loadErr !== 1'b0) $display("FAIL %s_loadErr got=%b want=0", tag, bus.loadErr); else n_pass++;
    n_checks++; if (bus.cpuHold !== 1'b0) $display("FAIL %s_cpuHold_end got=%b want=0", tag, bus.cpuHold); else n_pass++;
  endtask

  task automatic test_bad_count();
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h11);
    repeat (2) @(negedge clk);
    n_checks++; if (bus.loadErr !== 1'b1) $display("FAIL cnt17_loadErr got=%b want=1", bus.loadErr); else n_pass++;
    n_checks++; if (bus.cpuHold !== 1'b1) $display("FAIL cnt17_cpuHold got=%b want=1", bus.cpuHold); else n_pass++;
    n_checks++; if (bus.loadDone !== 1'b0) $display("FAIL cnt17_loadDone got=%b want=0", bus.loadDone); else n_pass++;
    n_checks++; if (wr_addr.size() != 0) $display("FAIL cnt17_writes got=%0d want=0", wr_addr.size()); else n_pass++;
    send_byte(8'hA5);
    n_checks++; if (bus.loadErr !== 1'b0) $display("FAIL resync_clears_err got=%b want=0", bus.loadErr); else n_pass++;
    send_byte(8'h00);
    @(negedge clk);
    n_checks++; if (bus.loadErr !== 1'b1) $display("FAIL cnt0_loadErr got=%b want=1", bus.loadErr); else n_pass++;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h22);
`endif
    repeat (2) @(negedge clk);
    n_checks++; if (bus.loadDone !== 1'b1 || bus.loadErr !== 1'b0)
      $display("FAIL recover_status got=%b%b want=10", bus.loadDone, bus.loadErr); else n_pass++;
    n_checks++; if (wr_data.size() != 1 || wr_data[0] !== 32'hEFBEADDE)
      $display("FAIL recover_word n=%0d want=1 word=efbeadde", wr_data.size()); else n_pass++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    clear_log();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_byte(8'h2B);
    repeat (2) @(negedge clk);
    n_checks++; if (wr_addr.size() != 2) $display("FAIL cs_nwrites got=%0d want=2", wr_addr.size()); else n_pass++;
    n_checks++; if (bus.loadErr !== 1'b1 || bus.loadDone !== 1'b0)
      $display("FAIL cs_status got=err%b done%b want=err1 done0", bus.loadErr, bus.loadDone); else n_pass++;
    n_checks++; if (bus.cpuHold !== 1'b1) $display("FAIL cs_cpuHold got=%b want=1", bus.cpuHold); else n_pass++;
  endtask
`endif

  task automatic test_timeout();
    clear_log();
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    repeat (15) @(negedge clk);
    n_checks++; if (bus.loadErr !== 1'b0) $display("FAIL tmo_early got=%b want=0", bus.loadErr); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.loadErr !== 1'b1) $display("FAIL tmo_at16 got=%b want=1", bus.loadErr); else n_pass++;
    n_checks++; if (bus.cpuHold !== 1'b1 || wr_addr.size() != 0)
      $display("FAIL tmo_hold_nowrite got=%b/%0d want=1/0", bus.cpuHold, wr_addr.size()); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h78);
    nrst = 1'b0;
    #1;
    n_checks++; if (bus.cpuHold !== 1'b0 || bus.loadDone !== 1'b0 || bus.loadErr !== 1'b0)
      $display("FAIL midrst_status got=%b%b%b want=000", bus.cpuHold, bus.loadDone, bus.loadErr); else n_pass++;
    n_checks++; if (bus.imemWEn !== 1'b0 || bus.imemAddr !== 4'd0 || bus.imemWData !== 32'd0 || bus.rxReady !== 1'b1)
      $display("FAIL midrst_bus got=%b/%h/%h/%b want=0/0/0/1", bus.imemWEn, bus.imemAddr, bus.imemWData, bus.rxReady);
    else n_pass++;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    test_load("rerun");
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    bus.rxValid = 1'b1;
    bus.rxData  = 8'h55;
    n_checks++; if (bus.rxReady !== 1'b0 || bus.imemWEn !== 1'b1)
      $display("FAIL b2b_stall got=rdy%b wen%b want=rdy0 wen1", bus.rxReady, bus.imemWEn); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.rxReady !== 1'b1) $display("FAIL b2b_ready_after got=%b want=1", bus.rxReady); else n_pass++;
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h88);
`endif
    repeat (2) @(negedge clk);
    n_checks++; if (wr_data.size() != 2) $display("FAIL b2b_nwrites got=%0d want=2", wr_data.size());
    else if (wr_data[0] !== 32'h44332211 || wr_data[1] !== 32'h88776655)
      $display("FAIL b2b_words got=%h,%h want=44332211,88776655", wr_data[0], wr_data[1]);
    else n_pass++;
    n_checks++; if (bus.loadDone !== 1'b1) $display("FAIL b2b_done got=%b want=1", bus.loadDone); else n_pass++;
  endtask

  task automatic test_sync_as_data();
    clear_log();
    send_byte(8'hA5); send_byte(8'h01);
    repeat (4) send_byte(8'hA5);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    repeat (2) @(negedge clk);
    n_checks++; if (wr_data.size() != 1 || wr_data[0] !== 32'hA5A5A5A5 || bus.loadDone !== 1'b1)
      $display("FAIL a5data got=n%0d done%b want=n1 word=a5a5a5a5 done1", wr_data.size(), bus.loadDone);
    else n_pass++;
  endtask

  task automatic test_max_image();
    int bad;
    clear_log();
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    repeat (2) @(negedge clk);
    n_checks++; if (wr_addr.size() != 16) $display("FAIL max_nwrites got=%0d want=16", wr_addr.size()); else n_pass++;
    if (wr_addr.size() == 16) begin
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        if (wr_addr[i] !== 4'(i) ||
            wr_data[i] !== {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}) bad++;
      end
      n_checks++; if (bad != 0) $display("FAIL max_words got=%0d bad want=0 (last %h:%h)", bad, wr_addr[15], wr_data[15]);
      else n_pass++;
    end
    n_checks++; if (bus.loadDone !== 1'b1 || bus.loadErr !== 1'b0 || bus.cpuHold !== 1'b0)
      $display("FAIL max_status got=%b%b%b want=100", bus.loadDone, bus.loadErr, bus.cpuHold); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    nrst     = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxData  = 8'h00;
    @(negedge clk);
    test_reset();
    test_idle_drop();
    test_load("load");
    test_bad_count();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    test_sync_as_data();
    test_max_image();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
